// File: rtl/spi_prog_seq_if.sv
// Command-engine bus between spi_prog_seq (master) and the downstream SPI command engine (slave).
interface spi_prog_seq_if;
  logic          cmd_trigger;
  logic          cmd_busy;
  logic [8:0]    cmd_in_count;
  logic [7:0]    cmd_out_count;
  logic [2079:0] cmd_data_in;
  logic [63:0]   cmd_data_out;
  logic          cmd_quad;

  modport master (
    output cmd_trigger, cmd_in_count, cmd_out_count, cmd_data_in, cmd_quad,
    input  cmd_busy, cmd_data_out
  );

  modport slave (
    input  cmd_trigger, cmd_in_count, cmd_out_count, cmd_data_in, cmd_quad,
    output cmd_busy, cmd_data_out
  );
endinterface

// File: rtl/spi_prog_seq.sv
// SPI flash read / page-program / sector-erase sequencer driving a generic SPI command engine.
// Optional status-poll timeout enabled by defining SPI_PROG_SEQ_POLL_TIMEOUT_EN.
module spi_prog_seq #(
  parameter int unsigned POLL_MAX = 1000000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [23:0]    addr,
  input  logic [8:0]     len,
  input  logic [2047:0]  wdata,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [63:0]    rdata,
  spi_prog_seq_if.master cmd
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WREN, S_OPCMD, S_POLL, S_CHECK, S_FINISH} state_t;
  typedef enum logic [1:0] {PH_LAUNCH, PH_ACK, PH_CPLT} phase_t;

  state_t          state;
  phase_t          phase;
  logic [1:0]      op_q;
  logic [23:0]     addr_q;
  logic [8:0]      len_q;
  logic [2047:0]   wdata_q;
  logic            timeout_hit;

`ifdef SPI_PROG_SEQ_POLL_TIMEOUT_EN
  logic [31:0]     poll_cnt;
  assign timeout_hit = (poll_cnt >= POLL_MAX);
`else
  // Without the timeout the poll loop never gives up; the limit has no effect.
  assign timeout_hit = 1'b0 && (POLL_MAX != 0);
`endif

  assign cmd.cmd_quad = 1'b0;

  function automatic logic legal_req(input logic [1:0] o, input logic [8:0] n);
    case (o)
      OP_READ:  return (n != 9'd0) && (n <= 9'd8);
      OP_PROG:  return (n != 9'd0) && (n <= 9'd256);
      OP_ERASE: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  // Opcode and address occupy the top four bytes; payload byte 0 follows them.
  function automatic logic [2079:0] op_frame(input logic [1:0] o, input logic [23:0] a,
                                             input logic [8:0] n, input logic [2047:0] wd);
    logic [2079:0] f;
    f = '0;
    case (o)
      OP_READ:  f[31:0] = {8'h03, a};
      OP_PROG: begin
        for (int k = 0; k < 256; k++)
          if (k < int'(n)) f[8*(int'(n)-1-k) +: 8] = wd[8*k +: 8];
        f[8*int'(n) +: 32] = {8'h02, a};
      end
      OP_ERASE: f[31:0] = {8'hD8, a};
      default:  f = '0;
    endcase
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      op_q    <= op;
      addr_q  <= addr;
      len_q   <= len;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      phase             <= PH_LAUNCH;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      rdata             <= '0;
      cmd.cmd_trigger   <= 1'b0;
      cmd.cmd_in_count  <= '0;
      cmd.cmd_out_count <= '0;
      cmd.cmd_data_in   <= '0;
`ifdef SPI_PROG_SEQ_POLL_TIMEOUT_EN
      poll_cnt          <= '0;
`endif
    end else begin
      done            <= 1'b0;
      cmd.cmd_trigger <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal_req(op, len)) begin
              busy  <= 1'b1;
              error <= 1'b0;
              phase <= PH_LAUNCH;
              state <= (op == OP_READ) ? S_OPCMD : S_WREN;
            end else begin
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_FINISH;
            end
          end
        end
        S_WREN, S_OPCMD, S_POLL: begin
          case (phase)
            PH_LAUNCH: begin
              if (!cmd.cmd_busy) begin
                cmd.cmd_trigger <= 1'b1;
                phase           <= PH_ACK;
                if (state == S_WREN) begin
                  cmd.cmd_data_in   <= 2080'(8'h06);
                  cmd.cmd_in_count  <= 9'd1;
                  cmd.cmd_out_count <= 8'd0;
                end else if (state == S_OPCMD) begin
                  cmd.cmd_data_in   <= op_frame(op_q, addr_q, len_q, wdata_q);
                  cmd.cmd_in_count  <= (op_q == OP_PROG) ? 9'd4 + len_q : 9'd4;
                  cmd.cmd_out_count <= (op_q == OP_READ) ? len_q[7:0] : 8'd0;
                end else begin
                  cmd.cmd_data_in   <= 2080'(8'h05);
                  cmd.cmd_in_count  <= 9'd1;
                  cmd.cmd_out_count <= 8'd1;
`ifdef SPI_PROG_SEQ_POLL_TIMEOUT_EN
                  poll_cnt          <= poll_cnt + 32'd1;
`endif
                end
              end
            end
            PH_ACK: if (cmd.cmd_busy) phase <= PH_CPLT;
            default: begin
              if (!cmd.cmd_busy) begin
                phase <= PH_LAUNCH;
                if (state == S_WREN) begin
                  state <= S_OPCMD;
                end else if (state == S_OPCMD && op_q == OP_READ) begin
                  rdata <= cmd.cmd_data_out;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  error <= 1'b0;
                  state <= S_FINISH;
                end else if (state == S_OPCMD) begin
`ifdef SPI_PROG_SEQ_POLL_TIMEOUT_EN
                  poll_cnt <= '0;
`endif
                  state <= S_POLL;
                end else begin
                  state <= S_CHECK;
                end
              end
            end
          endcase
        end
        S_CHECK: begin
          if (cmd.cmd_data_out[0] && !timeout_hit) begin
            phase <= PH_LAUNCH;
            state <= S_POLL;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= cmd.cmd_data_out[0];
            state <= S_FINISH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_prog_seq.sv
// Scoreboard bench for spi_prog_seq: a behavioural flash/engine model answers command frames,
// a frame-level reference model predicts every engine frame and every completion.
module tb_spi_prog_seq;
  localparam int PM = 5;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [8:0]    n;
    logic [7:0]    o;
    logic [2079:0] d;
    logic [63:0]   resp;
  } frame_t;
  typedef struct {
    bit          err;
    bit          chk_rd;
    logic [63:0] rd;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    op;
  logic [23:0]   addr;
  logic [8:0]    len;
  logic [2047:0] wdata;
  logic          busy, done, error;
  logic [63:0]   rdata;

  spi_prog_seq_if bus();

  spi_prog_seq #(.POLL_MAX(PM)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr), .len(len),
    .wdata(wdata), .busy(busy), .done(done), .error(error), .rdata(rdata), .cmd(bus)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  int     trig_count = 0;
  frame_t fq[$];
  txn_t   txq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [2079:0] act, input logic [2079:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual_lo=%0h required_lo=%0h", nm, act[127:0], exp[127:0]);
    end
  endtask

  // Reference model: frames are lists of bytes, byte 0 sent first.
  function automatic bit legal_ref(input logic [1:0] o, input int n);
    if (o == 2'b11) return 0;
    if (o == 2'b00) return n >= 1 && n <= 8;
    if (o == 2'b01) return n >= 1 && n <= 256;
    return 1;
  endfunction

  task automatic push_frame(input bytes_t q, input int outc, input logic [63:0] resp);
    frame_t f;
    int n;
    n = q.size();
    f.d = '0;
    for (int j = 0; j < n; j++) f.d[8*(n-j)-8 +: 8] = q[j];
    f.n = 9'(n);
    f.o = 8'(outc);
    f.resp = resp;
    fq.push_back(f);
  endtask

  task automatic push_op(input logic [1:0] o, input logic [23:0] a, input int n,
                         input logic [2047:0] wd, input int wip, input logic [63:0] rv);
    bytes_t b;
    int np;
    bit e;
    if (!legal_ref(o, n)) begin
      txq.push_back('{1'b1, 1'b0, 64'd0});
      return;
    end
    if (o != 2'b00) begin
      b = {8'h06};
      push_frame(b, 0, 64'd0);
    end
    b = {(o == 2'b00) ? 8'h03 : (o == 2'b01) ? 8'h02 : 8'hD8, a[23:16], a[15:8], a[7:0]};
    if (o == 2'b01) for (int k = 0; k < n; k++) b.push_back(wd[8*k +: 8]);
    push_frame(b, (o == 2'b00) ? n : 0, (o == 2'b00) ? rv : 64'd0);
    if (o == 2'b00) begin
      txq.push_back('{1'b0, 1'b1, rv});
      return;
    end
`ifdef SPI_PROG_SEQ_POLL_TIMEOUT_EN
    np = (wip >= PM) ? PM : wip + 1;
    e  = (wip >= PM);
`else
    np = wip + 1;
    e  = 1'b0;
`endif
    for (int p = 0; p < np; p++) begin
      b = {8'h05};
      push_frame(b, 1, {63'd0, p < wip});
    end
    txq.push_back('{e, 1'b0, 64'd0});
  endtask

  // Command engine model: busy through reset, then answers each trigger after a random delay.
  int            eng_st, eng_cnt;
  bit            eng_first;
  logic [63:0]   cur_resp;
  logic [2079:0] cap_d;
  frame_t        cur;
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.cmd_busy     = 1'b1;
      bus.cmd_data_out = '0;
      eng_st  = 0;
      eng_cnt = 3;
    end else begin
      case (eng_st)
        0: if (eng_cnt > 0) eng_cnt--; else begin bus.cmd_busy = 1'b0; eng_st = 1; end
        1: if (bus.cmd_trigger) begin
          trig_count++;
          cap_d = bus.cmd_data_in;
          if (fq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_trigger actual=in_count %0d required=no trigger", bus.cmd_in_count);
            cur_resp = '0;
          end else begin
            cur = fq.pop_front();
            chk("in_count", 64'(bus.cmd_in_count), 64'(cur.n));
            chk("out_count", 64'(bus.cmd_out_count), 64'(cur.o));
            chk_frame("frame", bus.cmd_data_in, cur.d);
            cur_resp = cur.resp;
          end
          eng_cnt = $urandom_range(2, 0);
          eng_first = 1'b1;
          eng_st = 2;
        end
        2: begin
          if (eng_first) begin chk("trigger_width", 64'(bus.cmd_trigger), 64'd0); eng_first = 1'b0; end
          if (eng_cnt > 0) eng_cnt--;
          else begin bus.cmd_busy = 1'b1; eng_cnt = $urandom_range(4, 1); eng_st = 3; end
        end
        default: if (eng_cnt > 0) eng_cnt--; else begin
          chk_frame("frame_hold", bus.cmd_data_in, cap_d);
          bus.cmd_data_out = cur_resp;
          bus.cmd_busy = 1'b0;
          eng_st = 1;
        end
      endcase
    end
  end

  // Completion monitor.
  txn_t t;
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (txq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=done required=none");
      end else begin
        t = txq.pop_front();
        chk("error", 64'(error), 64'(t.err));
        chk("busy_at_done", 64'(busy), 64'd0);
        if (t.chk_rd) chk("rdata", rdata, t.rd);
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i <= budget; i++) begin
      if (done) return;
      if (i < budget) @(negedge clk);
    end
    total++; bad++;
    $display("FAIL done_timeout actual=no done required=done within %0d cycles", budget);
  endtask

  task automatic issue(input logic [1:0] o, input logic [23:0] a, input int n,
                       input logic [2047:0] wd, input int wip, input logic [63:0] rv);
    push_op(o, a, n, wd, wip, rv);
    op = o; addr = a; len = 9'(n); wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [23:0] a, input int n,
                        input logic [2047:0] wd, input int wip, input logic [63:0] rv);
    issue(o, a, n, wd, wip, rv);
    wait_done(legal_ref(o, n) ? 3000 : 0);
    @(negedge clk);
  endtask

  logic [2047:0] wd;
  logic [63:0]   rv;
  int            r, n, tc;
  logic [1:0]    o;
  bit            seen;

  initial begin
    reset_n = 1'b0; start = 1'b0; op = '0; addr = '0; len = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_trigger", 64'(bus.cmd_trigger), 0);
    chk("rst_in_count", 64'(bus.cmd_in_count), 0);
    chk("rst_out_count", 64'(bus.cmd_out_count), 0);
    chk_frame("rst_frame", bus.cmd_data_in, '0);
    chk("quad", 64'(bus.cmd_quad), 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 24'h012345, 4, '0, 0, 64'hDEADBEEF);
    wd = '0; wd[7:0] = 8'hA5; wd[15:8] = 8'h5A;
    issue(2'b01, 24'h000100, 2, wd, 3, 0);
    repeat (4) @(negedge clk);
    op = 2'b00; addr = 24'hFFFFFF; len = 9'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000);
    @(negedge clk);
    run_op(2'b10, 24'h010000, 0, '0, 0, 0);
    tc = trig_count;
    run_op(2'b11, 24'h000000, 4, '0, 0, 0);
    run_op(2'b00, 24'h000000, 9, '0, 0, 0);
    chk("illegal_triggers", 64'(trig_count - tc), 0);
    run_op(2'b10, 24'h020000, 0, '0, 20, 0);

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(9, 0);
      o = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      r = $urandom_range(9, 0);
      if (o == 2'b00) n = $urandom_range(9, 0);
      else if (r == 0) n = 0;
      else if (r == 1) n = $urandom_range(511, 257);
      else n = $urandom_range(256, 1);
      for (int k = 0; k < 64; k++) wd[32*k +: 32] = $urandom;
      rv = {$urandom, $urandom};
      if (n >= 1 && n < 8) rv = rv & ((64'd1 << (8 * n)) - 64'd1);
      run_op(o, 24'($urandom), n, wd, $urandom_range(3, 0), rv);
    end

    issue(2'b01, 24'h000100, 2, wd, 1, 0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_trigger && bus.cmd_in_count == 9'd6) seen = 1'b1;
    end
    chk("opcmd_seen", 64'(seen), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_error", 64'(error), 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_trigger", 64'(bus.cmd_trigger), 0);
    chk("abort_in_count", 64'(bus.cmd_in_count), 0);
    chk("abort_out_count", 64'(bus.cmd_out_count), 0);
    chk_frame("abort_frame", bus.cmd_data_in, '0);
    fq.delete();
    txq.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tc = trig_count;
    repeat (30) @(negedge clk);
    chk("post_reset_triggers", 64'(trig_count - tc), 0);
    run_op(2'b00, 24'hABCDEF, 8, '0, 0, 64'h0123456789ABCDEF);

    chk("frames_left", 64'(fq.size()), 0);
    chk("txns_left", 64'(txq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
